even_par_frame_rx: RTL and testbench

EVEN_PAR_FRAME_RX -- requirements
Module: even_par_frame_rx

---
 rtl/even_par_frame_rx.sv | 145 ++++++++++++++
 tb/tb_even_par_frame_rx.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/even_par_frame_rx.sv
// rtl/even_par_frame_rx.sv - serial frame receiver: start, DATA_W bits LSB first, even parity, stop.
module even_par_frame_rx #(
   parameter int DATA_W       = 4,
   parameter int CLKS_PER_BIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rx_in,
   output logic [DATA_W-1:0] Data,
   output logic              Even_parity,
   output logic              valid,
   output logic              par_err,
   output logic              frame_err,
   output logic              busy
);

   localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT/2 - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [DATA_W-1:0]   shift_q, shift_d;
   logic                par_bit_q, par_bit_d;
   logic                sync1_q, sync1_d;
   logic                rx_s_q, rx_s_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic                even_par_q, even_par_d;
   logic                valid_q, valid_d;
   logic                par_err_q, par_err_d;
   logic                frame_err_q, frame_err_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         idx_q       <= '0;
         shift_q     <= '0;
         par_bit_q   <= 1'b0;
         sync1_q     <= 1'b1;
         rx_s_q      <= 1'b1;
         data_q      <= '0;
         even_par_q  <= 1'b0;
         valid_q     <= 1'b0;
         par_err_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         shift_q     <= shift_d;
         par_bit_q   <= par_bit_d;
         sync1_q     <= sync1_d;
         rx_s_q      <= rx_s_d;
         data_q      <= data_d;
         even_par_q  <= even_par_d;
         valid_q     <= valid_d;
         par_err_q   <= par_err_d;
         frame_err_q <= frame_err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      shift_d     = shift_q;
      par_bit_d   = par_bit_q;
      sync1_d     = rx_in;
      rx_s_d      = sync1_q;
      data_d      = data_q;
      even_par_d  = even_par_q;
      valid_d     = 1'b0;
      par_err_d   = par_err_q;
      frame_err_d = frame_err_q;
      case (state_q)
         IDLE: begin
            if (!rx_s_q) begin
               state_d = START;
               cnt_d   = '0;
            end
         end
         START: begin
            // Mid-start-bit recheck: a line back high here was only a glitch.
            if (cnt_q == CNT_HALF) begin
               if (rx_s_q) begin
                  state_d = IDLE;
               end else begin
                  state_d = DATA;
                  cnt_d   = '0;
                  idx_d   = '0;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DATA: begin
            if (cnt_q == CNT_FULL) begin
               shift_d[idx_q] = rx_s_q;
               cnt_d          = '0;
               if (idx_q == IDX_LAST) state_d = PARITY;
               else                   idx_d   = idx_q + IDX_W'(1);
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         PARITY: begin
            if (cnt_q == CNT_FULL) begin
               par_bit_d = rx_s_q;
               cnt_d     = '0;
               state_d   = STOP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         STOP: begin
            if (cnt_q == CNT_FULL) begin
               data_d      = shift_q;
               even_par_d  = par_bit_q;
               par_err_d   = ^{shift_q, par_bit_q};
               frame_err_d = ~rx_s_q;
               valid_d     = 1'b1;
               cnt_d       = '0;
               state_d     = IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign Data        = data_q;
   assign Even_parity = even_par_q;
   assign valid       = valid_q;
   assign par_err     = par_err_q;
   assign frame_err   = frame_err_q;
   assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_even_par_frame_rx.sv
// tb/tb_even_par_frame_rx.sv - directed scoreboard bench for even_par_frame_rx.
module tb_even_par_frame_rx;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx_in = 1'b1;
   logic [3:0] Data;
   logic       Even_parity;
   logic       valid;
   logic       par_err;
   logic       frame_err;
   logic       busy;

   typedef struct packed {
      logic [3:0] data;
      logic       parity;
      logic       perr;
      logic       ferr;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad = 0;
   int   valid_cnt = 0;
   int   cyc = 0;
   int   valid_cyc[$];

   even_par_frame_rx #(.DATA_W(4), .CLKS_PER_BIT(4)) dut (
      .clk(clk), .rst(rst), .rx_in(rx_in), .Data(Data),
      .Even_parity(Even_parity), .valid(valid), .par_err(par_err),
      .frame_err(frame_err), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && valid === 1'b1) begin
         exp_t e;
         valid_cnt++;
         valid_cyc.push_back(cyc);
         if (exp_q.size() == 0) begin
            check("unexpected_valid", 32'(valid), 32'(0));
         end else begin
            e = exp_q.pop_front();
            check("data", 32'(Data), 32'(e.data));
            check("even_parity", 32'(Even_parity), 32'(e.parity));
            check("par_err", 32'(par_err), 32'(e.perr));
            check("frame_err", 32'(frame_err), 32'(e.ferr));
         end
      end
   end

   task automatic line_bit(input logic b);
      rx_in = b;
      repeat (4) @(negedge clk);
   endtask

   task automatic send(input logic [3:0] d, input logic p, input logic stp, input logic perr);
      exp_t e;
      e.data = d; e.parity = p; e.perr = perr; e.ferr = ~stp;
      exp_q.push_back(e);
      line_bit(1'b0);
      for (int i = 0; i < 4; i++) line_bit(d[i]);
      line_bit(p);
      line_bit(stp);
   endtask

   task automatic check_outputs(input string tag, input logic [3:0] d, input logic p,
                                input logic pe, input logic fe);
      check({tag, "_data"}, 32'(Data), 32'(d));
      check({tag, "_par"}, 32'(Even_parity), 32'(p));
      check({tag, "_perr"}, 32'(par_err), 32'(pe));
      check({tag, "_ferr"}, 32'(frame_err), 32'(fe));
   endtask

   initial begin
      int  vc;
      logic seen_busy;
      repeat (3) @(negedge clk);
      check_outputs("reset", 4'h0, 1'b0, 1'b0, 1'b0);
      check("reset_valid", 32'(valid), 32'(0));
      check("reset_busy", 32'(busy), 32'(0));
      rst = 1'b0;
      repeat (4) @(negedge clk);

      send(4'b1011, 1'b1, 1'b1, 1'b0);
      rx_in = 1'b1; repeat (8) @(negedge clk);
      send(4'b1011, 1'b0, 1'b1, 1'b1);
      rx_in = 1'b1; repeat (8) @(negedge clk);
      send(4'b0110, 1'b0, 1'b0, 1'b0);
      rx_in = 1'b1; repeat (8) @(negedge clk);
      check_outputs("hold", 4'b0110, 1'b0, 1'b0, 1'b1);

      vc = valid_cnt;
      seen_busy = 1'b0;
      rx_in = 1'b0; @(negedge clk);
      rx_in = 1'b1;
      repeat (12) begin
         @(negedge clk);
         if (busy) seen_busy = 1'b1;
      end
      check("glitch_busy_seen", 32'(seen_busy), 32'(1));
      check("glitch_busy_end", 32'(busy), 32'(0));
      check("glitch_no_valid", 32'(valid_cnt), 32'(vc));
      check_outputs("glitch", 4'b0110, 1'b0, 1'b0, 1'b1);

      send(4'b0001, 1'b1, 1'b1, 1'b0);
      send(4'b1111, 1'b0, 1'b1, 1'b0);
      rx_in = 1'b1; repeat (8) @(negedge clk);
      check("b2b_count", 32'(valid_cnt), 32'(5));
      if (valid_cyc.size() >= 5)
         check("b2b_spacing", 32'(valid_cyc[4] - valid_cyc[3]), 32'(28));

      vc = valid_cnt;
      rx_in = 1'b0; repeat (4) @(negedge clk);
      rx_in = 1'b1; repeat (6) @(negedge clk);
      rst = 1'b1;
      #1;
      check_outputs("midrst", 4'h0, 1'b0, 1'b0, 1'b0);
      check("midrst_valid", 32'(valid), 32'(0));
      check("midrst_busy", 32'(busy), 32'(0));
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (30) @(negedge clk);
      check("midrst_no_valid", 32'(valid_cnt), 32'(vc));
      check_outputs("after_rst", 4'h0, 1'b0, 1'b0, 1'b0);

      send(4'b0101, 1'b0, 1'b1, 1'b0);
      rx_in = 1'b1; repeat (10) @(negedge clk);

      check("final_valid_count", 32'(valid_cnt), 32'(6));
      check("scoreboard_empty", 32'(exp_q.size()), 32'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
